// File: rtl/leiwand_rv32_uart_loader_pkg.sv
// Shared constants, state encodings and bus payload type for the UART boot loader.
package leiwand_rv32_uart_loader_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MEM_WIDTH_BYTES = XLEN / 8;

    // Loader session states
    localparam logic [2:0] LDR_S_LEN   = 3'd0;
    localparam logic [2:0] LDR_S_DATA  = 3'd1;
    localparam logic [2:0] LDR_S_FLUSH = 3'd2;
    localparam logic [2:0] LDR_S_CSUM  = 3'd3;
    localparam logic [2:0] LDR_S_DONE  = 3'd4;

    // UART receiver states
    localparam logic [1:0] RX_S_IDLE  = 2'd0;
    localparam logic [1:0] RX_S_START = 2'd1;
    localparam logic [1:0] RX_S_DATA  = 2'd2;
    localparam logic [1:0] RX_S_STOP  = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]            addr;
        logic [XLEN-1:0]            data;
        logic [MEM_WIDTH_BYTES-1:0] wen;
    } mem_req_t;

    // Byte enables for lanes 0..last_lane, contiguous from bit 0
    function automatic logic [MEM_WIDTH_BYTES-1:0] lane_wen(input logic [1:0] last_lane);
        logic [MEM_WIDTH_BYTES-1:0] wen;
        wen = '0;
        for (int i = 0; i < int'(MEM_WIDTH_BYTES); i++) begin
            wen[i] = (i <= int'(last_lane));
        end
        return wen;
    endfunction

endpackage

// File: rtl/leiwand_rv32_uart_loader_rx.sv
// 8N1 UART receiver: input synchroniser, start-bit glitch rejection, bit timing, framing check.
module leiwand_rv32_uart_rx
    import leiwand_rv32_uart_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_byte,
    output logic       o_ferr
);

    localparam int unsigned        CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    logic [1:0]       r_sync;
    logic             r_prev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic [7:0]       r_byte;
    logic             r_ferr;

    logic             w_rx;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_valid_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_ferr_nxt;

    assign w_rx = r_sync[1];

    // Bit timing: sample mid-start, then every CLK_DIV clocks for data and stop
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_byte_nxt  = r_byte;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_prev && !w_rx) begin
                    w_state_nxt = RX_S_START;
                end
            end
            RX_S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = 3'd0;
                    w_state_nxt = w_rx ? RX_S_IDLE : RX_S_DATA;
                end
            end
            RX_S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            RX_S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_S_IDLE;
                    if (w_rx) begin
                        w_valid_nxt = 1'b1;
                        w_byte_nxt  = r_shift;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RX_S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_valid <= 1'b0;
            r_byte  <= 8'd0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            r_prev  <= w_rx;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_byte  <= w_byte_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    assign o_valid = r_valid;
    assign o_byte  = r_byte;
    assign o_ferr  = r_ferr;

endmodule

// File: rtl/leiwand_rv32_uart_loader.sv
// UART boot loader: length-prefixed byte stream packed into LE words and written over the memory bus.
// Optional trailing checksum byte enabled by LEIWAND_RV32_LOADER_CHECKSUM_EN.
module leiwand_rv32_uart_loader
    import leiwand_rv32_uart_loader_pkg::*;
#(
    parameter int unsigned     CLK_DIV        = 434,
    parameter logic [XLEN-1:0] LOAD_BASE_ADDR = 32'h8000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx,
    output logic                       o_mem_valid,
    input  logic                       i_mem_ready,
    output logic [XLEN-1:0]            o_mem_addr,
    output logic [XLEN-1:0]            o_mem_data,
    output logic [MEM_WIDTH_BYTES-1:0] o_mem_wen,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_DATA = LDR_S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = LDR_S_DONE;
`endif

    logic            w_rx_valid;
    logic [7:0]      w_rx_byte;
    logic            w_rx_ferr;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_len;
    logic [XLEN-1:0] r_cnt;
    logic [XLEN-1:0] r_word;
    mem_req_t        r_req;
    logic            r_mem_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            r_abort;

    logic [2:0]      w_state_nxt;
    logic [XLEN-1:0] w_len_nxt;
    logic [XLEN-1:0] w_cnt_nxt;
    logic [XLEN-1:0] w_word_nxt;
    logic [XLEN-1:0] w_word_fill;
    mem_req_t        w_req_nxt;
    logic            w_mem_valid_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_error_nxt;
    logic            w_abort_nxt;
    logic            w_pending;
    logic            w_last;
    logic [1:0]      w_lane;

`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
    logic [7:0]      w_csum_nxt;
`endif

    leiwand_rv32_uart_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rx    (i_rx),
        .o_valid (w_rx_valid),
        .o_byte  (w_rx_byte),
        .o_ferr  (w_rx_ferr)
    );

    // A write still outstanding after this cycle occupies the single holding slot
    assign w_pending = r_mem_valid & ~i_mem_ready;
    assign w_lane    = r_cnt[1:0];
    assign w_last    = (r_cnt == r_len - XLEN'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_word_nxt      = r_word;
        w_req_nxt       = r_req;
        w_mem_valid_nxt = w_pending;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_error_nxt     = r_error;
        w_abort_nxt     = r_abort;
        w_word_fill     = r_word;
        w_word_fill[{w_lane, 3'b000} +: 8] = w_rx_byte;
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
        w_csum_nxt      = r_csum;
`endif
        case (r_state)
            LDR_S_LEN: begin
                if (w_rx_valid) begin
                    if (w_lane == 2'd0) begin
                        w_busy_nxt  = 1'b1;
                        w_error_nxt = 1'b0;
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
                        w_csum_nxt  = 8'd0;
`endif
                    end
                    w_len_nxt[{w_lane, 3'b000} +: 8] = w_rx_byte;
                    if (w_lane == 2'd3) begin
                        w_cnt_nxt   = '0;
                        w_word_nxt  = '0;
                        w_state_nxt = (w_len_nxt == '0) ? S_AFTER_DATA : LDR_S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + XLEN'(1);
                    end
                end
            end
            LDR_S_DATA: begin
                if (w_rx_valid) begin
                    w_word_nxt = w_word_fill;
                    w_cnt_nxt  = r_cnt + XLEN'(1);
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
                    w_csum_nxt = r_csum + w_rx_byte;
`endif
                    if (w_last) begin
                        w_state_nxt = LDR_S_FLUSH;
                    end
                    if (w_lane == 2'd3 || w_last) begin
                        w_word_nxt = '0;
                        if (w_pending) begin
                            // Overrun: drop the new word, let the pending one finish, then abort
                            w_error_nxt = 1'b1;
                            w_abort_nxt = 1'b1;
                            w_state_nxt = LDR_S_FLUSH;
                        end else begin
                            w_mem_valid_nxt = 1'b1;
                            w_req_nxt.addr  = LOAD_BASE_ADDR + {r_cnt[XLEN-1:2], 2'b00};
                            w_req_nxt.data  = w_word_fill;
                            w_req_nxt.wen   = lane_wen(w_lane);
                        end
                    end
                end
            end
            LDR_S_FLUSH: begin
                if (!w_pending) begin
                    if (r_abort) begin
                        w_state_nxt = LDR_S_LEN;
                        w_busy_nxt  = 1'b0;
                        w_abort_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_AFTER_DATA;
                    end
                end
            end
            LDR_S_CSUM: begin
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
                if (w_rx_valid) begin
                    if (w_rx_byte != r_csum) begin
                        w_error_nxt = 1'b1;
                    end
                    w_state_nxt = LDR_S_DONE;
                end
`else
                w_state_nxt = LDR_S_LEN;
`endif
            end
            LDR_S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = LDR_S_LEN;
            end
            default: w_state_nxt = LDR_S_LEN;
        endcase
        // Framing error aborts the session once any pending write has drained
        if (w_rx_ferr) begin
            w_error_nxt = 1'b1;
            if (r_state != LDR_S_DONE) begin
                w_abort_nxt = 1'b1;
                w_state_nxt = LDR_S_FLUSH;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= LDR_S_LEN;
            r_len       <= '0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_req       <= '0;
            r_mem_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_abort     <= 1'b0;
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_word      <= w_word_nxt;
            r_req       <= w_req_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_abort     <= w_abort_nxt;
`ifdef LEIWAND_RV32_LOADER_CHECKSUM_EN
            r_csum      <= w_csum_nxt;
`endif
        end
    end

    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_req.addr;
    assign o_mem_data  = r_req.data;
    assign o_mem_wen   = r_req.wen;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule
